vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync / back porch in clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-005 clk_clk  in  1  pixel clock (25 MHz nominal); single clock domain, all logic rising-edge.
REQ-006 reset_reset_n  in  1  synchronous, active-low reset.
REQ-007 en  in  1  timing enable; low holds the generator idle.
REQ-008 px_req  out  1  pixel fetch request to frame-buffer reader, one pixel per cycle.
REQ-009 px_x  out  10  column of requested pixel.
REQ-010 px_y  out  9  row of requested pixel.
REQ-011 px_data  in  24  {R,G,B} of requested pixel, valid exactly 1 clock after px_req.
REQ-012 frame_start  out  1  one-cycle pulse at first request of each frame.
REQ-013 vga_CLK  out  1  pixel clock forwarded to DAC (equals clk_clk).
REQ-014 vga_HS / vga_VS  out  1 each  active-low horizontal / vertical sync.
REQ-015 vga_BLANK  out  1  high during visible video, low during blanking (DAC BLANK_N sense).
REQ-016 vga_SYNC  out  1  composite sync, constant 0.
REQ-017 vga_R / vga_G / vga_B  out  8 each  pixel colour.

Function
REQ-018 h_cnt counts 0..H_TOTAL-1 (H_TOTAL = 800) then wraps to 0; v_cnt increments on each h_cnt wrap, counts 0..V_TOTAL-1 (V_TOTAL = 525), wraps to 0.
REQ-019 Stage 0 (combinational from counters): active = en & (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE); px_req = active; px_x = h_cnt, px_y = v_cnt when active, else 0.
REQ-020 frame_start = en & (h_cnt == 0) & (v_cnt == 0).
REQ-021 Stage 0 sync decode: hs_n low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); vs_n low iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-022 Stage 1 register: active, hs_n, vs_n delayed 1 clock to align with px_data.
REQ-023 Stage 2 register: vga_HS, vga_VS, vga_BLANK = stage-1 hs_n, vs_n, active; vga_R/G/B = px_data[23:16]/[15:8]/[7:0] if stage-1 active else 0.
REQ-024 Total latency counter-to-pins = 2 clocks; HS, VS, BLANK, RGB mutually aligned at pins.
REQ-025 en low: counters held at 0, px_req = 0, frame_start = 0; pipeline continues to drain, so pins reach idle (HS=1, VS=1, BLANK=0, RGB=0) within 2 clocks.
REQ-026 en rising: counting starts at (0,0) on that cycle, frame_start pulses, first px_req same cycle; en falling mid-frame aborts frame, next enable restarts at (0,0).
REQ-027 RGB never nonzero while vga_BLANK = 0, regardless of px_data.
REQ-028 Counter wrap at (799,524) goes to (0,0) in one clock with frame_start asserted that cycle if en high.

Reset
REQ-029 While reset_reset_n low at a clock edge: h_cnt = v_cnt = 0, all pipeline registers cleared.
REQ-030 Reset output values: px_req = 0, px_x = 0, px_y = 0, frame_start = 0, vga_HS = 1, vga_VS = 1, vga_BLANK = 0, vga_SYNC = 0, RGB = 0.
REQ-031 Reset asserted mid-frame: takes effect at next edge; first cycle after release with en = 1 is (0,0) with frame_start = 1.

Verification
REQ-032 Reset release, en = 1 -> frame_start at cycle 0; px_req high cycles 0..639, low 640..799 of each line; 800 clocks per line, 420000 clocks per frame.
REQ-033 px_data = {8'hAA,8'h55,8'h0F} one cycle after each req -> pins show R=AA, G=55, B=0F with BLANK=1 exactly 2 clocks after each px_req cycle; RGB=0 elsewhere.
REQ-034 Sync check -> vga_HS low for 96 clocks starting 658 clocks after line start (656 + 2 latency); vga_VS low for 1600 clocks (lines 490-491).
REQ-035 px_data driven 24'hFFFFFF constantly -> RGB zero throughout all blanking intervals.
REQ-036 en dropped at (h=300, v=100) for 10 clocks -> px_req 0 same cycle, pins idle by 2 clocks, restart at (0,0) with frame_start pulse.
REQ-037 Reset pulsed at (h=700, v=520) -> all outputs at reset values next edge; counting restarts from (0,0) after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: frame counters, pixel fetch requests and sync/blank/RGB pins.
// Latency 2 clocks counter-to-pins; no backpressure, px_data must follow px_req by one clock.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        en,
  output logic        px_req,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  input  logic [23:0] px_data,
  output logic        frame_start,
  output logic        vga_CLK,
  output logic        vga_HS,
  output logic        vga_VS,
  output logic        vga_BLANK,
  output logic        vga_SYNC,
  output logic [7:0]  vga_R,
  output logic [7:0]  vga_G,
  output logic [7:0]  vga_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  logic          run;
  logic          active_s0;
  logic          hs_n_s0;
  logic          vs_n_s0;

  logic          act1_q, act1_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;

  logic          blank_q, blank_d;
  logic          hs2_q, hs2_d;
  logic          vs2_q, vs2_d;
  logic [23:0]   rgb_q, rgb_d;

  // Reset gates stage 0 too, so the request side is quiet while reset is held.
  assign run = en & reset_reset_n;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0: decode straight from the counters.
  always_comb begin
    active_s0 = run & (h_cnt_q < H_ACT_END) & (v_cnt_q < V_ACT_END);
    hs_n_s0   = ~(run & (h_cnt_q >= HS_START) & (h_cnt_q < HS_END));
    vs_n_s0   = ~(run & (v_cnt_q >= VS_START) & (v_cnt_q < VS_END));
  end

  always_comb begin
    px_req      = active_s0;
    px_x        = '0;
    px_y        = '0;
    frame_start = run & (h_cnt_q == '0) & (v_cnt_q == '0);
    if (active_s0) begin
      px_x = 10'(h_cnt_q);
      px_y = 9'(v_cnt_q);
    end
  end

  // Stage 1 lines control up with px_data; stage 2 drives the pins.
  always_comb begin
    act1_d  = active_s0;
    hs1_d   = hs_n_s0;
    vs1_d   = vs_n_s0;
    blank_d = act1_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    rgb_d   = '0;
    if (act1_q) begin
      rgb_d = px_data;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      act1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      blank_q <= 1'b0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      rgb_q   <= '0;
    end else begin
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      blank_q <= blank_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga_CLK   = clk_clk;
  assign vga_HS    = hs2_q;
  assign vga_VS    = vs2_q;
  assign vga_BLANK = blank_q;
  assign vga_SYNC  = 1'b0;
  assign vga_R     = rgb_q[23:16];
  assign vga_G     = rgb_q[15:8];
  assign vga_B     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: one default-geometry and one shrunken-geometry generator driven in lockstep,
// both compared every cycle against a frame-position reference model.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] px_data;

  logic        o_req   [2];
  logic [9:0]  o_x     [2];
  logic [8:0]  o_y     [2];
  logic        o_fs    [2];
  logic        o_clk   [2];
  logic        o_hs    [2];
  logic        o_vs    [2];
  logic        o_blank [2];
  logic        o_sync  [2];
  logic [7:0]  o_r     [2];
  logic [7:0]  o_g     [2];
  logic [7:0]  o_b     [2];

  always #5 clk = ~clk;

  vga_timing_gen u_dut_std (
    .clk_clk(clk), .reset_reset_n(rst_n), .en(en),
    .px_req(o_req[0]), .px_x(o_x[0]), .px_y(o_y[0]), .px_data(px_data),
    .frame_start(o_fs[0]), .vga_CLK(o_clk[0]), .vga_HS(o_hs[0]), .vga_VS(o_vs[0]),
    .vga_BLANK(o_blank[0]), .vga_SYNC(o_sync[0]),
    .vga_R(o_r[0]), .vga_G(o_g[0]), .vga_B(o_b[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_small (
    .clk_clk(clk), .reset_reset_n(rst_n), .en(en),
    .px_req(o_req[1]), .px_x(o_x[1]), .px_y(o_y[1]), .px_data(px_data),
    .frame_start(o_fs[1]), .vga_CLK(o_clk[1]), .vga_HS(o_hs[1]), .vga_VS(o_vs[1]),
    .vga_BLANK(o_blank[1]), .vga_SYNC(o_sync[1]),
    .vga_R(o_r[1]), .vga_G(o_g[1]), .vga_B(o_b[1])
  );

  int ha  [2] = '{640, 16};
  int hf  [2] = '{16, 4};
  int hsy [2] = '{96, 6};
  int hb  [2] = '{48, 5};
  int va  [2] = '{480, 10};
  int vf  [2] = '{10, 2};
  int vsy [2] = '{2, 2};
  int vb  [2] = '{33, 3};

  typedef struct packed {
    logic       req;
    logic [9:0] x;
    logic [8:0] y;
    logic       fs;
    logic       hs_n;
    logic       vs_n;
  } s0_t;

  localparam s0_t S0_IDLE = '{req: 1'b0, x: 10'd0, y: 9'd0, fs: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          pos    [2];
  s0_t         s0_h1  [2];
  s0_t         s0_h2  [2];
  logic        rst_h1;
  logic [23:0] px_h1;

  function automatic int htot(int k);
    return ha[k] + hf[k] + hsy[k] + hb[k];
  endfunction

  function automatic int ftot(int k);
    return htot(k) * (va[k] + vf[k] + vsy[k] + vb[k]);
  endfunction

  // Position p counts pixel clocks since the frame began; h/v follow from division.
  function automatic s0_t model_s0(int k, bit eff, int p);
    s0_t s;
    int  h;
    int  v;
    bit  act;
    h   = p % htot(k);
    v   = p / htot(k);
    act = eff && (h < ha[k]) && (v < va[k]);
    s.req  = act;
    s.x    = act ? 10'(h) : 10'd0;
    s.y    = act ? 9'(v) : 9'd0;
    s.fs   = eff && (p == 0);
    s.hs_n = !(eff && (h >= ha[k] + hf[k]) && (h < ha[k] + hf[k] + hsy[k]));
    s.vs_n = !(eff && (v >= va[k] + vf[k]) && (v < va[k] + vf[k] + vsy[k]));
    return s;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [23:0] d);
    s0_t  e0;
    logic ehs, evs, eblank;
    logic [23:0] ergb;
    @(negedge clk);
    rst_n   = r;
    en      = e;
    px_data = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      e0 = model_s0(k, r && e, pos[k]);
      if (!rst_h1) begin
        ehs = 1'b1; evs = 1'b1; eblank = 1'b0; ergb = 24'd0;
      end else begin
        ehs    = s0_h2[k].hs_n;
        evs    = s0_h2[k].vs_n;
        eblank = s0_h2[k].req;
        ergb   = s0_h2[k].req ? px_h1 : 24'd0;
      end
      chk("px_req", k, 32'(o_req[k]), 32'(e0.req));
      chk("px_x", k, 32'(o_x[k]), 32'(e0.x));
      chk("px_y", k, 32'(o_y[k]), 32'(e0.y));
      chk("frame_start", k, 32'(o_fs[k]), 32'(e0.fs));
      chk("vga_HS", k, 32'(o_hs[k]), 32'(ehs));
      chk("vga_VS", k, 32'(o_vs[k]), 32'(evs));
      chk("vga_BLANK", k, 32'(o_blank[k]), 32'(eblank));
      chk("vga_R", k, 32'(o_r[k]), 32'(ergb[23:16]));
      chk("vga_G", k, 32'(o_g[k]), 32'(ergb[15:8]));
      chk("vga_B", k, 32'(o_b[k]), 32'(ergb[7:0]));
      chk("vga_SYNC", k, 32'(o_sync[k]), 32'd0);
      chk("vga_CLK", k, 32'(o_clk[k]), 32'(clk));
      s0_h2[k] = s0_h1[k];
      s0_h1[k] = e0;
      pos[k]   = (r && e) ? (pos[k] + 1) % ftot(k) : 0;
    end
    rst_h1 = r;
    px_h1  = d;
    cyc++;
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    en      = 1'b0;
    px_data = 24'd0;
    rst_h1  = 1'b0;
    px_h1   = 24'd0;
    for (int k = 0; k < 2; k++) begin
      pos[k]   = 0;
      s0_h1[k] = S0_IDLE;
      s0_h2[k] = S0_IDLE;
    end

    // Reset held with en high and garbage pixel data: everything must sit idle.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 24'($urandom()));

    // Release: first line of the full-size raster plus several small frames.
    for (int i = 0; i < 1100; i++) cycle(1'b1, 1'b1, 24'hAA550F);

    // Enable dropped mid-line (full-size raster at h=300, v=1) for 10 clocks.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 24'hAA550F);

    // Saturated pixel data: colour must still vanish during blanking.
    for (int i = 0; i < 3000; i++) cycle(1'b1, 1'b1, 24'hFFFFFF);

    // Walk the small raster to h=26, v=15 (late in the frame), then pulse reset.
    n = ((15 * 31 + 26) - pos[1] + ftot(1)) % ftot(1);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 24'($urandom()));
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 24'($urandom()));
    for (int i = 0; i < 1200; i++) cycle(1'b1, 1'b1, 24'($urandom()));

    // Random enable glitches, occasional resets and random pixel data.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 99) < 96), 24'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
